// File: rtl/pwm_pkg.sv
// pwm_pkg: constants and FSM state type shared by the PWM generator, the
// PWM decoder and their benches.
//   PWM_LVL_W   default duty-level width
//   pwm_period  nominal period in clocks for a given level width (2^lvl_w)
//   pwm_state_e decoder FSM states
package pwm_pkg;

  localparam int unsigned PWM_LVL_W = 32'd4;

  // Nominal PWM period: one clock per representable level.
  function automatic int unsigned pwm_period(input int unsigned lvl_w);
    return 32'd1 << lvl_w;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MEASURE  = 2'd1,
    ST_STUCK_LO = 2'd2,
    ST_STUCK_HI = 2'd3
  } pwm_state_e;

endpackage

// File: rtl/pwm_decoder_sync_ff.sv
// sync_ff: STAGES-deep flop chain bringing an asynchronous single-bit input
// into the clk domain.
// Ports:
//   clk      system clock
//   i_rst_n  asynchronous active-low reset, clears every stage
//   i_d      asynchronous input
//   o_q      synchronised copy of i_d, STAGES clocks late
module sync_ff #(
  parameter int unsigned STAGES = 32'd2
) (
  input  logic clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] sync_d;
  logic [STAGES-1:0] sync_q;

  // Shift the input one stage deeper every clock.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], i_d};
  end

  // Synchroniser flops.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q <= {STAGES{1'b0}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign o_q = sync_q[STAGES-1];

endmodule

// File: rtl/pwm_decoder.sv
// pwm_decoder: recovers the duty level of an incoming PWM line whose period
// is PERIOD clocks and whose high time equals the level. Detects stuck-low
// (decoded as level 0), stuck-high and malformed periods.
// Ports:
//   clk       system clock, rising edge
//   i_rst_n   asynchronous active-low reset
//   i_pwm     PWM line, asynchronous to clk
//   o_lvl     last decoded level, held between updates
//   o_valid   one-cycle strobe when o_lvl is rewritten by a good decode
//   o_locked  high while the last period closed or timed out cleanly
//   o_err     one-cycle strobe on a period mismatch or a stuck-high line
module pwm_decoder
  import pwm_pkg::*;
#(
  parameter int unsigned LVL_W       = PWM_LVL_W,
  parameter int unsigned PERIOD      = pwm_period(LVL_W),
  parameter int unsigned SYNC_STAGES = 32'd2
) (
  input  logic             clk,
  input  logic             i_rst_n,
  input  logic             i_pwm,
  output logic [LVL_W-1:0] o_lvl,
  output logic             o_valid,
  output logic             o_locked,
  output logic             o_err
);

  localparam int unsigned      PER_W   = $clog2(2 * PERIOD + 1);
  localparam logic [PER_W-1:0] PER_NOM = PER_W'(PERIOD);
  localparam logic [PER_W-1:0] PER_MAX = PER_W'(2 * PERIOD);
  localparam logic [PER_W-1:0] PER_ONE = PER_W'(1);
  localparam logic [LVL_W:0]   HI_ONE  = (LVL_W + 1)'(1);
  localparam logic [LVL_W:0]   HI_MAX  = {(LVL_W + 1){1'b1}};
  localparam logic [LVL_W-1:0] LVL_MAX = {LVL_W{1'b1}};

  logic             sync_s;
  logic             rise_s;
  logic             timeout_s;
  logic             prev_d,    prev_q;
  pwm_state_e       state_d,   state_q;
  logic [PER_W-1:0] per_cnt_d, per_cnt_q;
  logic [LVL_W:0]   hi_cnt_d,  hi_cnt_q;
  logic [LVL_W-1:0] lvl_d,     lvl_q;
  logic             locked_d,  locked_q;
  logic             valid_d,   valid_q;
  logic             err_d,     err_q;
  // Output stage: decode results are retimed once more so they land three
  // edges after the closing edge is first sampled.
  logic [LVL_W-1:0] out_lvl_d,    out_lvl_q;
  logic             out_valid_d,  out_valid_q;
  logic             out_locked_d, out_locked_q;
  logic             out_err_d,    out_err_q;

  sync_ff #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_pwm),
    .o_q     (sync_s)
  );

  assign rise_s    = sync_s & ~prev_q;
  assign timeout_s = (per_cnt_q == PER_MAX);

  // Counters, FSM next state and decode results.
  always_comb begin
    prev_d       = sync_s;
    state_d      = state_q;
    lvl_d        = lvl_q;
    locked_d     = locked_q;
    valid_d      = 1'b0;
    err_d        = 1'b0;
    out_lvl_d    = lvl_q;
    out_valid_d  = valid_q;
    out_locked_d = locked_q;
    out_err_d    = err_q;

    // A rise opens a new period and already counts as its first (high) cycle.
    if (rise_s) begin
      per_cnt_d = PER_ONE;
      hi_cnt_d  = HI_ONE;
    end else begin
      per_cnt_d = (per_cnt_q == PER_MAX) ? per_cnt_q : per_cnt_q + PER_ONE;
      hi_cnt_d  = (sync_s && (hi_cnt_q != HI_MAX)) ? hi_cnt_q + HI_ONE : hi_cnt_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (rise_s) begin
          state_d = ST_MEASURE;
        end else if (timeout_s) begin
          state_d  = sync_s ? ST_STUCK_HI : ST_STUCK_LO;
          lvl_d    = sync_s ? LVL_MAX : {LVL_W{1'b0}};
          valid_d  = ~sync_s;
          err_d    = sync_s;
          locked_d = ~sync_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MEASURE: begin
        // Rise is checked first so it wins over a same-cycle timeout.
        if (rise_s) begin
          if (per_cnt_q == PER_NOM) begin
            lvl_d    = hi_cnt_q[LVL_W-1:0];
            valid_d  = 1'b1;
            locked_d = 1'b1;
          end else begin
            err_d    = 1'b1;
            locked_d = 1'b0;
          end
        end else if (timeout_s) begin
          state_d  = sync_s ? ST_STUCK_HI : ST_STUCK_LO;
          lvl_d    = sync_s ? LVL_MAX : {LVL_W{1'b0}};
          valid_d  = ~sync_s;
          err_d    = sync_s;
          locked_d = ~sync_s;
        end else begin
          state_d = ST_MEASURE;
        end
      end
      ST_STUCK_LO: begin
        // The edge ending a stuck-low spell only opens a new measurement.
        if (rise_s) begin
          state_d = ST_MEASURE;
        end else begin
          state_d = ST_STUCK_LO;
        end
      end
      ST_STUCK_HI: begin
        // No rise can occur while high; the falling edge restarts from scratch.
        if (!sync_s) begin
          state_d   = ST_IDLE;
          per_cnt_d = {PER_W{1'b0}};
          hi_cnt_d  = {(LVL_W + 1){1'b0}};
        end else begin
          state_d = ST_STUCK_HI;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counter, decode and output registers.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      prev_q       <= 1'b0;
      state_q      <= ST_IDLE;
      per_cnt_q    <= {PER_W{1'b0}};
      hi_cnt_q     <= {(LVL_W + 1){1'b0}};
      lvl_q        <= {LVL_W{1'b0}};
      locked_q     <= 1'b0;
      valid_q      <= 1'b0;
      err_q        <= 1'b0;
      out_lvl_q    <= {LVL_W{1'b0}};
      out_valid_q  <= 1'b0;
      out_locked_q <= 1'b0;
      out_err_q    <= 1'b0;
    end else begin
      prev_q       <= prev_d;
      state_q      <= state_d;
      per_cnt_q    <= per_cnt_d;
      hi_cnt_q     <= hi_cnt_d;
      lvl_q        <= lvl_d;
      locked_q     <= locked_d;
      valid_q      <= valid_d;
      err_q        <= err_d;
      out_lvl_q    <= out_lvl_d;
      out_valid_q  <= out_valid_d;
      out_locked_q <= out_locked_d;
      out_err_q    <= out_err_d;
    end
  end

  assign o_lvl    = out_lvl_q;
  assign o_valid  = out_valid_q;
  assign o_locked = out_locked_q;
  assign o_err    = out_err_q;

endmodule

// File: tb/tb_pwm_decoder.sv
// tb_pwm_decoder: drives PWM segments (high time, low time) into pwm_decoder.
// Each segment start pushes the response expected from the edge that closes
// the previous segment; a separate monitor pops and compares on every strobe.
`timescale 1ns/1ps
module tb_pwm_decoder;

  localparam int LVL_W = 4;
  localparam int PER   = 16;

  logic             clk = 1'b0;
  logic             i_rst_n;
  logic             i_pwm;
  logic [LVL_W-1:0] o_lvl;
  logic             o_valid;
  logic             o_locked;
  logic             o_err;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  typedef struct {
    int kind;  // 1 = valid strobe, 2 = err strobe
    int lvl;
    int lock;
    int cyc;
  } exp_t;
  exp_t exp_q[$];

  // Stimulus-side bookkeeping for the open period.
  int opened   = 0;
  int prev_hi  = 0;
  int prev_len = 0;
  int last_lvl = 0;
  int rise_c   = 0;

  pwm_decoder #(
    .LVL_W       (LVL_W),
    .PERIOD      (PER),
    .SYNC_STAGES (2)
  ) dut (
    .clk      (clk),
    .i_rst_n  (i_rst_n),
    .i_pwm    (i_pwm),
    .o_lvl    (o_lvl),
    .o_valid  (o_valid),
    .o_locked (o_locked),
    .o_err    (o_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void push(input int k, input int l, input int lk, input int c);
    exp_t e;
    e.kind = k;
    e.lvl  = l;
    e.lock = lk;
    e.cyc  = c;
    exp_q.push_back(e);
  endfunction

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (i_rst_n && (o_valid || o_err)) begin
        check("strobe_exclusive", int'(o_valid && o_err), 0);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_strobe: got valid=%0d err=%0d lvl=%0d at cycle %0d, expected no strobe",
                   o_valid, o_err, o_lvl, cyc);
        end else begin
          e = exp_q.pop_front();
          check("strobe_kind", o_err ? 2 : 1, e.kind);
          check("strobe_lvl", int'(o_lvl), e.lvl);
          check("strobe_locked", int'(o_locked), e.lock);
          check("strobe_cycle", cyc, e.cyc);
        end
      end
    end
  endtask

  // One segment: i_pwm high for hi clocks then low for lo clocks.
  // A rise driven at cycle c is reported at cycle c+4 (2 sync + prev + output);
  // a timeout 2*PER cycles after a rise is reported at c+4+2*PER.
  task automatic run_seg(input int hi, input int lo);
    for (int i = 0; i < hi + lo; i++) begin
      @(negedge clk);
      if (i == 0) begin
        if (hi > 0) begin
          if (opened != 0) begin
            if (prev_len == PER) begin
              push(1, prev_hi, 1, cyc + 4);
              last_lvl = prev_hi;
            end else begin
              push(2, last_lvl, 0, cyc + 4);
            end
          end
          opened   = 1;
          rise_c   = cyc;
          prev_hi  = hi;
          prev_len = hi + lo;
          if (hi >= 2 * PER) begin
            push(2, 15, 0, rise_c + 4 + 2 * PER);
            last_lvl = 15;
            opened   = 0;
          end
        end else if (opened != 0) begin
          push(1, 0, 1, rise_c + 4 + 2 * PER);
          last_lvl = 0;
          opened   = 0;
        end
      end
      i_pwm = (i < hi);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded 100000 ns, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    i_rst_n = 1'b0;
    i_pwm   = 1'b0;
    fork
      monitor();
    join_none

    repeat (3) @(negedge clk);
    check("reset_lvl", int'(o_lvl), 0);
    check("reset_valid", int'(o_valid), 0);
    check("reset_locked", int'(o_locked), 0);
    check("reset_err", int'(o_err), 0);
    i_rst_n = 1'b1;

    // Steady level 2, then steps 2 -> 15 -> 8 -> 14 -> 8.
    for (int n = 0; n < 10; n++) run_seg(2, 14);
    for (int n = 0; n < 5; n++)  run_seg(15, 1);
    for (int n = 0; n < 5; n++)  run_seg(8, 8);
    for (int n = 0; n < 5; n++)  run_seg(14, 2);
    for (int n = 0; n < 3; n++)  run_seg(8, 8);

    // Level 0: line stays low, single strobe at the timeout.
    run_seg(0, 48);
    check("stuck_lo_lvl", int'(o_lvl), 0);
    check("stuck_lo_locked", int'(o_locked), 1);

    // Stuck high for 40 clocks, then resume at level 3.
    run_seg(40, 5);
    check("stuck_hi_lvl", int'(o_lvl), 15);
    check("stuck_hi_locked", int'(o_locked), 0);
    for (int n = 0; n < 3; n++) run_seg(3, 13);

    // One 17-clock period in a level-5 stream.
    for (int n = 0; n < 3; n++) run_seg(5, 11);
    run_seg(5, 12);
    for (int n = 0; n < 3; n++) run_seg(5, 11);
    check("after_mismatch_locked", int'(o_locked), 1);

    // Reset in the middle of a period.
    run_seg(6, 10);
    run_seg(6, 10);
    run_seg(6, 4);
    @(negedge clk);
    i_rst_n = 1'b0;
    #1;
    check("midreset_lvl", int'(o_lvl), 0);
    check("midreset_valid", int'(o_valid), 0);
    check("midreset_locked", int'(o_locked), 0);
    check("midreset_err", int'(o_err), 0);
    repeat (3) @(negedge clk);
    i_rst_n = 1'b1;
    opened  = 0;
    for (int n = 0; n < 3; n++) run_seg(6, 10);

    repeat (8) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
